watch_chain_reader: RTL and testbench

- Debugger-side controller for the CPU watch scan chains: drives the scan clock and the CaptureDR/ShiftDR controls, then serially reads back one chain.
- Shifts the chain out LSB first into a parallel word and presents the word on a valid/ready output.
- Sits in the debugger/virtual-panel logic, on the opposite end of the CPU scan ports.

---
 rtl/jtag_watch_pkg.sv | 20 ++
 rtl/scan_tck_gen.sv | 40 ++++
 rtl/watch_chain_reader.sv | 111 +++++++++++
 tb/tb_watch_chain_reader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_watch_pkg.sv
// Shared types and constants for the watch scan-chain reader.
// Holds the controller state encoding, the {ShiftDR,CaptureDR} codes and a width helper.
package jtag_watch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [1:0] CTRL_IDLE    = 2'b00;
    localparam logic [1:0] CTRL_CAPTURE = 2'b01;
    localparam logic [1:0] CTRL_SHIFT   = 2'b10;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_tck_gen.sv
// Scan clock generator: divides clk by 2*DIV into a registered TCK with edge strobes.
// Latency: first rising TCK DIV cycles after en goes high; strobes coincide with the toggle edge.
// Backpressure: none; dropping en parks TCK low and clears the divider immediately.
module scan_tck_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic scan_clk,
    output logic rise,
    output logic fall
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic          term;

    assign term = en && (cnt == TERM);
    assign rise = term && !scan_clk;
    assign fall = term && scan_clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            scan_clk <= 1'b0;
        end else if (!en) begin
            cnt      <= '0;
            scan_clk <= 1'b0;
        end else if (term) begin
            cnt      <= '0;
            scan_clk <= ~scan_clk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/watch_chain_reader.sv
// Captures one CPU watch scan chain and reads it back LSB first into a parallel word.
// Latency: 2*DIV*(1+LENsel)+1 cycles from start to valid; holds the word until accepted.
// Backpressure: oValid/iReady on the output; iStart is dropped (not queued) while busy.
module watch_chain_reader
    import jtag_watch_pkg::*;
#(
    parameter int  LEN1   = 64,
    parameter int  LEN2   = 16,
    parameter int  DIV    = 2,
    localparam int MAXLEN = max(LEN1, LEN2)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              iStart,
    input  logic              iSel,
    output logic              oBusy,
    output logic              oScanClk,
    output logic              oScanIn,
    input  logic              iScanOut1,
    input  logic              iScanOut2,
    output logic [1:0]        oScanCtrl1,
    output logic [1:0]        oScanCtrl2,
    output logic [MAXLEN-1:0] oData,
    output logic              oValid,
    input  logic              iReady
);

    localparam int BW = $clog2(MAXLEN + 1);

    state_t            state;
    logic              sel;
    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     len_sel;
    logic              scan_bit;
    logic              tck_en;
    logic              tck_rise;
    logic              tck_fall;

    assign oScanIn  = 1'b0;
    assign len_sel  = sel ? BW'(LEN2) : BW'(LEN1);
    assign scan_bit = sel ? iScanOut2 : iScanOut1;
    assign tck_en   = (state == CAPTURE) || (state == SHIFT);

    scan_tck_gen #(
        .DIV (DIV)
    ) u_tck (
        .clk      (Clk),
        .rst_n    (Reset),
        .en       (tck_en),
        .scan_clk (oScanClk),
        .rise     (tck_rise),
        .fall     (tck_fall)
    );

    // Control codes only change on a falling strobe or while TCK is parked low,
    // so the chain always sees DIV cycles of setup before the next rising edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            sel        <= 1'b0;
            bit_cnt    <= '0;
            oData      <= '0;
            oValid     <= 1'b0;
            oBusy      <= 1'b0;
            oScanCtrl1 <= CTRL_IDLE;
            oScanCtrl2 <= CTRL_IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        sel        <= iSel;
                        oData      <= '0;
                        oBusy      <= 1'b1;
                        oScanCtrl1 <= iSel ? CTRL_IDLE : CTRL_CAPTURE;
                        oScanCtrl2 <= iSel ? CTRL_CAPTURE : CTRL_IDLE;
                        state      <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (tck_fall) begin
                        bit_cnt    <= '0;
                        oScanCtrl1 <= sel ? CTRL_IDLE : CTRL_SHIFT;
                        oScanCtrl2 <= sel ? CTRL_SHIFT : CTRL_IDLE;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Sampled before the chain acts on this rising edge: bit0 of the chain.
                    if (tck_rise && (bit_cnt != len_sel)) begin
                        oData   <= oData | (MAXLEN'(scan_bit) << bit_cnt);
                        bit_cnt <= bit_cnt + 1'b1;
                    end else if (tck_fall && (bit_cnt == len_sel)) begin
                        oScanCtrl1 <= CTRL_IDLE;
                        oScanCtrl2 <= CTRL_IDLE;
                        oValid     <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (oValid && iReady) begin
                        oValid <= 1'b0;
                        oBusy  <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_watch_chain_reader.sv
// Drives three readers (DIV=1,2,3; LEN1=8, LEN2=4) from shared stimulus, each wired to its own chain pair.
// Expected words, edge counts and latencies come from the chain rules, not from the controller structure.
module tb_watch_chain_reader;

    localparam int N = 3;

    logic       Clk    = 1'b0;
    logic       Reset  = 1'b1;
    logic       iStart = 1'b0;
    logic       iSel   = 1'b0;
    logic       iReady = 1'b0;
    logic [7:0] data1;
    logic [3:0] data2;

    logic       sclk  [N];
    logic       sin   [N];
    logic [1:0] ctl1  [N];
    logic [1:0] ctl2  [N];
    logic [7:0] odata [N];
    logic       valid [N];
    logic       busy  [N];

    int         n_chk  = 0;
    int         n_pass = 0;
    int         ncyc   = 0;
    logic       exp_sel;
    logic [7:0] exp_word;
    int         rises     [N];
    int         age       [N];
    int         vld_at    [N];
    int         base      [N];
    logic       prev_sclk [N];
    logic [3:0] prev_ctl  [N];

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [7:0] ch1;
        logic [3:0] ch2;

        // Chains act on rising TCK: capture loads, shift moves toward bit0.
        always @(posedge sclk[g]) begin
            if (ctl1[g] == 2'b01)      ch1 <= data1;
            else if (ctl1[g] == 2'b10) ch1 <= {sin[g], ch1[7:1]};
            if (ctl2[g] == 2'b01)      ch2 <= data2;
            else if (ctl2[g] == 2'b10) ch2 <= {sin[g], ch2[3:1]};
        end

        watch_chain_reader #(
            .LEN1 (8),
            .LEN2 (4),
            .DIV  (g + 1)
        ) u_dut (
            .Clk        (Clk),
            .Reset      (Reset),
            .iStart     (iStart),
            .iSel       (iSel),
            .oBusy      (busy[g]),
            .oScanClk   (sclk[g]),
            .oScanIn    (sin[g]),
            .iScanOut1  (ch1[0]),
            .iScanOut2  (ch2[0]),
            .oScanCtrl1 (ctl1[g]),
            .oScanCtrl2 (ctl2[g]),
            .oData      (odata[g]),
            .oValid     (valid[g]),
            .iReady     (iReady)
        );
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    // One cycle: advance to the falling edge and run the per-instance protocol monitors.
    task automatic tick();
        @(negedge Clk);
        ncyc++;
        for (int g = 0; g < N; g++) begin
            if ({ctl1[g], ctl2[g]} != prev_ctl[g]) begin
                check("ctrl_change_sclk_low", 32'(sclk[g]), 32'd0);
                age[g] = 0;
            end else begin
                age[g]++;
            end
            if (sclk[g] && !prev_sclk[g]) begin
                rises[g]++;
                check("ctrl_setup_cycles", 32'(age[g] >= g + 1), 32'd1);
            end
            check("unselected_ctrl", exp_sel ? 32'(ctl1[g]) : 32'(ctl2[g]), 32'd0);
            if (valid[g]) begin
                check("data_while_valid", 32'(odata[g]), 32'(exp_word));
                if (vld_at[g] < 0) vld_at[g] = ncyc;
            end
            prev_sclk[g] = sclk[g];
            prev_ctl[g]  = {ctl1[g], ctl2[g]};
        end
    endtask

    function automatic bit all_valid();
        for (int g = 0; g < N; g++) if (!valid[g]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic prepare(input logic sel, input logic [7:0] d1, input logic [3:0] d2);
        exp_sel  = sel;
        data1    = d1;
        data2    = d2;
        exp_word = sel ? {4'h0, d2} : d1;
        for (int g = 0; g < N; g++) begin
            base[g]   = rises[g];
            vld_at[g] = -1;
        end
    endtask

    task automatic run_txn(input logic sel, input logic [7:0] d1, input logic [3:0] d2,
                           input int stall, input bit mid_pulse, input bit hs_start);
        int len;
        int t0;
        int n;
        len = sel ? 4 : 8;
        prepare(sel, d1, d2);
        iSel   = sel;
        iStart = 1'b1;
        t0     = ncyc;
        tick();
        iStart = 1'b0;
        iSel   = 1'($urandom);
        for (int g = 0; g < N; g++) check("busy_after_start", 32'(busy[g]), 32'd1);
        n = 0;
        while (!all_valid() && n < 300) begin
            iStart = (mid_pulse && n == 8);
            iSel   = 1'($urandom);
            tick();
            n++;
        end
        iStart = 1'b0;
        check("valid_timeout", 32'(all_valid()), 32'd1);
        for (int g = 0; g < N; g++) begin
            check("latency", 32'(vld_at[g] - t0), 32'(2 * (g + 1) * (1 + len) + 1));
            check("rising_edges", 32'(rises[g] - base[g]), 32'(1 + len));
            check("data", 32'(odata[g]), 32'(exp_word));
            check("sclk_low_done", 32'(sclk[g]), 32'd0);
        end
        repeat (stall) tick();
        for (int g = 0; g < N; g++) begin
            check("valid_held", 32'(valid[g]), 32'd1);
            check("busy_held", 32'(busy[g]), 32'd1);
        end
        iReady = 1'b1;
        if (hs_start) begin
            iStart = 1'b1;
            iSel   = ~sel;
        end
        tick();
        iReady = 1'b0;
        iStart = 1'b0;
        for (int g = 0; g < N; g++) begin
            check("valid_after_hs", 32'(valid[g]), 32'd0);
            check("busy_after_hs", 32'(busy[g]), 32'd0);
        end
        tick();
        for (int g = 0; g < N; g++) check("idle_after_hs", 32'(busy[g]), 32'd0);
    endtask

    initial begin
        int n;
        data1    = 8'h00;
        data2    = 4'h0;
        exp_sel  = 1'b0;
        exp_word = 8'h00;
        for (int g = 0; g < N; g++) begin
            rises[g]     = 0;
            age[g]       = 100;
            vld_at[g]    = -1;
            base[g]      = 0;
            prev_sclk[g] = 1'b0;
            prev_ctl[g]  = 4'h0;
        end

        #1 Reset = 1'b0;
        repeat (3) tick();
        for (int g = 0; g < N; g++) begin
            check("rst_sclk", 32'(sclk[g]), 32'd0);
            check("rst_ctrl", 32'({ctl1[g], ctl2[g]}), 32'd0);
            check("rst_valid", 32'(valid[g]), 32'd0);
            check("rst_busy", 32'(busy[g]), 32'd0);
            check("rst_data", 32'(odata[g]), 32'd0);
            check("rst_scan_in", 32'(sin[g]), 32'd0);
        end
        Reset = 1'b1;
        tick();

        run_txn(1'b0, 8'hA5, 4'h3, 0, 1'b0, 1'b0);
        run_txn(1'b1, 8'h5A, 4'hC, 10, 1'b0, 1'b0);
        run_txn(1'b0, 8'h96, 4'h7, 2, 1'b1, 1'b1);

        // Abort mid-shift with reset, then a fresh full capture with new chain contents.
        prepare(1'b0, 8'h11, 4'h0);
        iSel   = 1'b0;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        n = 0;
        while ((rises[1] - base[1]) < 4 && n < 100) begin
            tick();
            n++;
        end
        check("abort_reach_bit3", 32'((rises[1] - base[1]) >= 4), 32'd1);
        Reset = 1'b0;
        #1;
        for (int g = 0; g < N; g++) begin
            check("abort_sclk", 32'(sclk[g]), 32'd0);
            check("abort_ctrl", 32'({ctl1[g], ctl2[g]}), 32'd0);
            check("abort_valid", 32'(valid[g]), 32'd0);
            check("abort_busy", 32'(busy[g]), 32'd0);
        end
        repeat (2) tick();
        Reset = 1'b1;
        tick();
        run_txn(1'b0, 8'h3C, 4'h9, 1, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            run_txn(1'($urandom), 8'($urandom), 4'($urandom), int'($urandom_range(0, 6)),
                    1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
